// File: rtl/vram_pkg.sv
// Shared types and default widths for the video RAM arbiter.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 13;
  localparam int unsigned VRAM_DATA_W = 8;
  localparam int unsigned STARVE_W    = 4;

  typedef enum logic {
    SLOT_VIDEO  = 1'b0,
    SLOT_SHARED = 1'b1
  } slot_e;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_e;

endpackage

// File: rtl/vram_slot_sel.sv
// Shared-slot priority between CPU and loader, with a starvation counter
// that forces a loader slot after LD_MAX consecutive CPU wins.
module vram_slot_sel
  import vram_pkg::*;
#(
  parameter int unsigned LD_MAX = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   shared,
  input  logic   cpu_req,
  input  logic   ld_req,
  output grant_e grant_c
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(LD_MAX);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  always_comb begin
    grant_c  = GNT_IDLE;
    starve_d = starve_q;
    if (shared) begin
      if (ld_req && (starve_q == STARVE_MAX)) begin
        grant_c = GNT_LD;
      end else if (cpu_req) begin
        grant_c = GNT_CPU;
      end else if (ld_req) begin
        grant_c = GNT_LD;
      end
    end
    // A pending loader loses one more slot each time the CPU is served instead.
    if (!ld_req || (grant_c == GNT_LD)) begin
      starve_d = '0;
    end else if ((grant_c == GNT_CPU) && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Two-phase single-port video RAM schedule: even cycles serve video fetch,
// odd cycles are shared between the CPU bus and the loader write port.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W,
  parameter int unsigned LD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              cpu_clk,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  slot_e             phase_q, phase_d;
  grant_e            grant_c;
  logic              shared_c;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ld_ack_q, ld_ack_d;
  logic              rd_pend_q, rd_pend_d;

  assign shared_c = (phase_q == SLOT_SHARED);

  vram_slot_sel #(
    .LD_MAX (LD_MAX)
  ) u_slot_sel (
    .clk     (clk),
    .rst     (rst),
    .shared  (shared_c),
    .cpu_req (cpu_req),
    .ld_req  (ld_req),
    .grant_c (grant_c)
  );

  // RAM port mux; the video slot is never lent to another master.
  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    if (shared_c) begin
      unique case (grant_c)
        GNT_CPU: begin
          ram_addr  = cpu_addr;
          ram_we    = cpu_we;
          ram_wdata = cpu_wdata;
        end
        GNT_LD: begin
          ram_addr  = ld_addr;
          ram_we    = 1'b1;
          ram_wdata = ld_wdata;
        end
        default: ram_addr = cpu_addr;
      endcase
    end
  end

  // Read data lands one cycle after issue: video data in the shared slot,
  // CPU read data in the following video slot.
  always_comb begin
    phase_d     = shared_c ? SLOT_VIDEO : SLOT_SHARED;
    vid_data_d  = shared_c ? ram_rdata : vid_data_q;
    cpu_ack_d   = shared_c && (grant_c == GNT_CPU);
    ld_ack_d    = shared_c && (grant_c == GNT_LD);
    rd_pend_d   = cpu_ack_d && !cpu_we;
    cpu_rdata_d = rd_pend_q ? ram_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= SLOT_VIDEO;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign cpu_clk   = (phase_q == SLOT_SHARED);
  assign vid_data  = vid_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ld_ack    = ld_ack_q;

endmodule
